// File: rtl/diram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : diram_cmd_responder
// Brief    : SDR DRAM-side responder: per-bank row tracking, burst storage,
//            fixed-latency read return and sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module diram_cmd_responder #(
    parameter int BANK_W    = 5,
    parameter int ADDR_W    = 12,
    parameter int ROW_IDX_W = 4,
    parameter int COL_W     = 4,
    parameter int INTF_W    = 256,
    parameter int MASK_W    = INTF_W / 32,
    parameter int BURST     = 2,
    parameter int RD_LAT    = 4,
    parameter int WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dfi__phy__cs,
    input  logic              dfi__phy__cmd1,
    input  logic              dfi__phy__cmd0,
    input  logic [BANK_W-1:0] dfi__phy__bank,
    input  logic [ADDR_W-1:0] dfi__phy__addr,
    input  logic [INTF_W-1:0] dfi__phy__data,
    input  logic [MASK_W-1:0] dfi__phy__data_mask,
    output logic              phy__dfi__valid,
    output logic [INTF_W-1:0] phy__dfi__data,
    output logic              protocol_err
);

    localparam int c_NBANK     = 1 << BANK_W;
    localparam int c_IDX_W     = BANK_W + ROW_IDX_W + COL_W;
    localparam int c_DEPTH     = 1 << c_IDX_W;
    localparam int c_BEAT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int c_ADDR_USED = (ROW_IDX_W > COL_W) ? ROW_IDX_W : COL_W;

    localparam logic [1:0] c_CMD_ACT = 2'b00;
    localparam logic [1:0] c_CMD_RD  = 2'b01;
    localparam logic [1:0] c_CMD_WR  = 2'b10;
    localparam logic [1:0] c_CMD_PRE = 2'b11;

    typedef enum logic {
        BANK_CLOSED = 1'b0,
        BANK_OPEN   = 1'b1
    } bank_state_t;

    typedef struct packed {
        logic                 v;
        logic [BANK_W-1:0]    bank;
        logic [ROW_IDX_W-1:0] row;
        logic [COL_W-1:0]     col;
    } burst_cmd_t;

    bank_state_t          r_bank_st  [c_NBANK];
    bank_state_t          w_bank_nxt [c_NBANK];
    logic [ROW_IDX_W-1:0] r_bank_row [c_NBANK];
    logic [INTF_W-1:0]    r_mem      [c_DEPTH];

    burst_cmd_t r_rd_pipe [RD_LAT];
    burst_cmd_t r_wr_pipe [WR_LAT];
    burst_cmd_t r_rd_base, r_wr_base;
    burst_cmd_t w_rd_new, w_wr_new, w_rd_head, w_wr_head, w_rd_sel, w_wr_sel;

    logic [c_BEAT_W-1:0] r_rd_beat, r_wr_beat, r_rd_space, r_wr_space;
    logic                r_rd_act, r_wr_act;
    logic                r_valid, r_err, r_viol_d;
    logic [INTF_W-1:0]   r_data;

    logic [1:0]         w_cmd;
    logic               w_is_act, w_is_rd, w_is_wr, w_is_pre;
    logic               w_bank_open, w_rd_ok, w_wr_ok, w_viol;
    logic               w_rd_fire, w_wr_fire;
    logic [COL_W-1:0]   w_rd_col, w_wr_col;
    logic [c_IDX_W-1:0] w_rd_addr, w_wr_addr;
    logic               w_unused_addr;

    assign w_cmd         = {dfi__phy__cmd1, dfi__phy__cmd0};
    assign w_is_act      = dfi__phy__cs && (w_cmd == c_CMD_ACT);
    assign w_is_rd       = dfi__phy__cs && (w_cmd == c_CMD_RD);
    assign w_is_wr       = dfi__phy__cs && (w_cmd == c_CMD_WR);
    assign w_is_pre      = dfi__phy__cs && (w_cmd == c_CMD_PRE);
    assign w_bank_open   = (r_bank_st[dfi__phy__bank] == BANK_OPEN);
    assign w_unused_addr = ^dfi__phy__addr[ADDR_W-1:c_ADDR_USED];

    // A READ/WRITE needs an open bank and an idle spacing counter on its own path
    assign w_rd_ok = w_is_rd && w_bank_open && (r_rd_space == '0);
    assign w_wr_ok = w_is_wr && w_bank_open && (r_wr_space == '0);
    assign w_viol  = (w_is_act && w_bank_open) || (w_is_rd && !w_rd_ok) ||
                     (w_is_wr && !w_wr_ok);

    assign w_rd_new = '{v: w_rd_ok, bank: dfi__phy__bank,
                        row: r_bank_row[dfi__phy__bank], col: dfi__phy__addr[COL_W-1:0]};
    assign w_wr_new = '{v: w_wr_ok, bank: dfi__phy__bank,
                        row: r_bank_row[dfi__phy__bank], col: dfi__phy__addr[COL_W-1:0]};
    assign w_rd_head = r_rd_pipe[RD_LAT-1];
    assign w_wr_head = r_wr_pipe[WR_LAT-1];

    always_comb begin
        for (int b = 0; b < c_NBANK; b++) begin
            w_bank_nxt[b] = r_bank_st[b];
        end
        if (w_is_act) begin
            w_bank_nxt[dfi__phy__bank] = BANK_OPEN;
        end else if (w_is_pre) begin
            w_bank_nxt[dfi__phy__bank] = BANK_CLOSED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int b = 0; b < c_NBANK; b++) r_bank_st[b] <= BANK_CLOSED;
        end else begin
            for (int b = 0; b < c_NBANK; b++) r_bank_st[b] <= w_bank_nxt[b];
        end
    end

    always_ff @(posedge clk) begin
        if (w_is_act) begin
            r_bank_row[dfi__phy__bank] <= dfi__phy__addr[ROW_IDX_W-1:0];
        end
    end

    // Beat 0 comes straight from the pipeline head; later beats from the burst base
    always_comb begin
        w_rd_fire = 1'b0;
        w_rd_sel  = r_rd_base;
        w_rd_col  = r_rd_base.col + COL_W'(r_rd_beat);
        if (w_rd_head.v) begin
            w_rd_fire = 1'b1;
            w_rd_sel  = w_rd_head;
            w_rd_col  = w_rd_head.col;
        end else if (r_rd_act) begin
            w_rd_fire = 1'b1;
        end
    end

    always_comb begin
        w_wr_fire = 1'b0;
        w_wr_sel  = r_wr_base;
        w_wr_col  = r_wr_base.col + COL_W'(r_wr_beat);
        if (w_wr_head.v) begin
            w_wr_fire = 1'b1;
            w_wr_sel  = w_wr_head;
            w_wr_col  = w_wr_head.col;
        end else if (r_wr_act) begin
            w_wr_fire = 1'b1;
        end
    end

    assign w_rd_addr = {w_rd_sel.bank, w_rd_sel.row, w_rd_col};
    assign w_wr_addr = {w_wr_sel.bank, w_wr_sel.row, w_wr_col};

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int i = 0; i < RD_LAT; i++) r_rd_pipe[i] <= '0;
            for (int i = 0; i < WR_LAT; i++) r_wr_pipe[i] <= '0;
            r_rd_act   <= 1'b0;
            r_wr_act   <= 1'b0;
            r_rd_beat  <= '0;
            r_wr_beat  <= '0;
            r_rd_base  <= '0;
            r_wr_base  <= '0;
            r_rd_space <= '0;
            r_wr_space <= '0;
        end else begin
            r_rd_pipe[0] <= w_rd_new;
            for (int i = 1; i < RD_LAT; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
            r_wr_pipe[0] <= w_wr_new;
            for (int i = 1; i < WR_LAT; i++) r_wr_pipe[i] <= r_wr_pipe[i-1];

            if (w_rd_head.v) begin
                r_rd_act  <= (BURST > 1);
                r_rd_beat <= c_BEAT_W'(1);
                r_rd_base <= w_rd_head;
            end else if (r_rd_act) begin
                if (r_rd_beat == c_BEAT_W'(BURST - 1)) r_rd_act <= 1'b0;
                r_rd_beat <= r_rd_beat + 1'b1;
            end

            if (w_wr_head.v) begin
                r_wr_act  <= (BURST > 1);
                r_wr_beat <= c_BEAT_W'(1);
                r_wr_base <= w_wr_head;
            end else if (r_wr_act) begin
                if (r_wr_beat == c_BEAT_W'(BURST - 1)) r_wr_act <= 1'b0;
                r_wr_beat <= r_wr_beat + 1'b1;
            end

            if (w_rd_ok)                 r_rd_space <= c_BEAT_W'(BURST - 1);
            else if (r_rd_space != '0)   r_rd_space <= r_rd_space - 1'b1;
            if (w_wr_ok)                 r_wr_space <= c_BEAT_W'(BURST - 1);
            else if (r_wr_space != '0)   r_wr_space <= r_wr_space - 1'b1;
        end
    end

    // Storage is deliberately not reset so contents survive reset_poweron
    always_ff @(posedge clk) begin
        if (!reset_poweron && w_wr_fire) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (!dfi__phy__data_mask[l]) begin
                    r_mem[w_wr_addr][l*32 +: 32] <= dfi__phy__data[l*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_viol_d <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid  <= w_rd_fire;
            r_data   <= w_rd_fire ? r_mem[w_rd_addr] : '0;
            r_viol_d <= w_viol;
            r_err    <= r_err | r_viol_d;
        end
    end

    assign phy__dfi__valid = r_valid;
    assign phy__dfi__data  = r_data;
    assign protocol_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_diram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_diram_cmd_responder
// Brief    : Directed bench with a cycle-scheduled behavioural model of the
//            DIRAM responder plus literal burst expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diram_cmd_responder;

    localparam int c_RD_LAT = 4;
    localparam int c_WR_LAT = 1;
    localparam int c_BURST  = 2;

    localparam logic [1:0] c_ACT = 2'b00;
    localparam logic [1:0] c_RD  = 2'b01;
    localparam logic [1:0] c_WR  = 2'b10;
    localparam logic [1:0] c_PRE = 2'b11;

    localparam logic [255:0] c_A = {8{32'hAAAA_0001}};
    localparam logic [255:0] c_B = {8{32'hBBBB_0002}};
    localparam logic [255:0] c_C = {8{32'hCCCC_0003}};
    localparam logic [255:0] c_D = {8{32'hDDDD_0004}};
    localparam logic [255:0] c_E = {8{32'hEEEE_0005}};
    localparam logic [255:0] c_F = {8{32'hF0F0_0006}};
    localparam logic [255:0] c_G = {8{32'h1111_0007}};
    localparam logic [255:0] c_H = {8{32'h2222_0008}};
    localparam logic [255:0] c_I = {8{32'h3333_0009}};
    localparam logic [255:0] c_J = {8{32'h4444_000A}};
    localparam logic [255:0] c_ONES  = {8{32'hFFFF_FFFF}};
    localparam logic [255:0] c_LANE1 = {{6{32'h0}}, 32'hFFFF_FFFF, 32'h0};

    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         cs = 1'b0, cmd1 = 1'b0, cmd0 = 1'b0;
    logic [4:0]   bank = '0;
    logic [11:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic [7:0]   wmask = '0;
    logic         dut_valid, dut_err;
    logic [255:0] dut_data;

    int n_checks = 0;
    int n_pass   = 0;

    diram_cmd_responder dut (
        .clk                 (clk),
        .reset_poweron       (rst_in),
        .dfi__phy__cs        (cs),
        .dfi__phy__cmd1      (cmd1),
        .dfi__phy__cmd0      (cmd0),
        .dfi__phy__bank      (bank),
        .dfi__phy__addr      (addr),
        .dfi__phy__data      (wdata),
        .dfi__phy__data_mask (wmask),
        .phy__dfi__valid     (dut_valid),
        .phy__dfi__data      (dut_data),
        .protocol_err        (dut_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, req);
    endtask

    // Model: schedule beats by absolute cycle; reads see memory before this edge's write
    int           cyc = 0;
    bit           m_live = 0;
    bit           m_open [32];
    int           m_row  [32];
    int           m_last_rd, m_last_wr;
    int           m_rdq [int];
    int           m_wrq [int];
    logic [255:0] m_mem [int];
    bit           ex_v = 0, ex_err = 0, m_viol_d = 0;
    logic [255:0] ex_d = '0;

    always @(posedge clk) begin
        bit viol;
        int a;
        cyc++;
        if (rst_in) begin
            m_live = 1;
            ex_v = 0; ex_d = '0; ex_err = 0; m_viol_d = 0;
            m_last_rd = -100; m_last_wr = -100;
            m_rdq.delete(); m_wrq.delete();
            for (int b = 0; b < 32; b++) m_open[b] = 0;
        end else begin
            viol = 0;
            ex_err = ex_err | m_viol_d;
            if (m_rdq.exists(cyc)) begin
                a = m_rdq[cyc];
                ex_v = 1;
                ex_d = m_mem.exists(a) ? m_mem[a] : '0;
            end else begin
                ex_v = 0;
                ex_d = '0;
            end
            if (m_wrq.exists(cyc)) begin
                a = m_wrq[cyc];
                if (!m_mem.exists(a)) m_mem[a] = '0;
                for (int l = 0; l < 8; l++)
                    if (!wmask[l]) m_mem[a][l*32 +: 32] = wdata[l*32 +: 32];
            end
            if (cs) begin
                case ({cmd1, cmd0})
                    c_ACT: begin
                        if (m_open[bank]) viol = 1;
                        m_open[bank] = 1;
                        m_row[bank]  = int'(addr) % 16;
                    end
                    c_RD: begin
                        if (!m_open[bank] || (cyc - m_last_rd) < c_BURST) viol = 1;
                        else begin
                            m_last_rd = cyc;
                            for (int k = 0; k < c_BURST; k++)
                                m_rdq[cyc + c_RD_LAT + k] =
                                    int'(bank) * 256 + m_row[bank] * 16 + (int'(addr) + k) % 16;
                        end
                    end
                    c_WR: begin
                        if (!m_open[bank] || (cyc - m_last_wr) < c_BURST) viol = 1;
                        else begin
                            m_last_wr = cyc;
                            for (int k = 0; k < c_BURST; k++)
                                m_wrq[cyc + c_WR_LAT + k] =
                                    int'(bank) * 256 + m_row[bank] * 16 + (int'(addr) + k) % 16;
                        end
                    end
                    default: m_open[bank] = 0;
                endcase
            end
            m_viol_d = viol;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("valid", {255'b0, dut_valid}, {255'b0, ex_v});
            chk("data", dut_data, ex_d);
            chk("err", {255'b0, dut_err}, {255'b0, ex_err});
        end
    end

    task automatic step(input logic c, input logic [1:0] cm, input logic [4:0] bk,
                        input logic [11:0] ad, input logic [255:0] d, input logic [7:0] m);
        cs = c; cmd1 = cm[1]; cmd0 = cm[0]; bank = bk; addr = ad; wdata = d; wmask = m;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 5'd0, 12'd0, '0, 8'h00);
    endtask

    task automatic beat(input logic [255:0] d, input logic [7:0] m);
        step(1'b0, 2'b00, 5'd0, 12'd0, d, m);
    endtask

    task automatic read_and_check(input string nm, input logic [4:0] bk, input logic [11:0] col,
                                  input logic [255:0] e0, input logic [255:0] e1);
        step(1'b1, c_RD, bk, col, '0, 8'h00);
        idle(c_RD_LAT);
        chk({nm, "_v0"}, {255'b0, dut_valid}, 256'd1);
        chk({nm, "_d0"}, dut_data, e0);
        idle(1);
        chk({nm, "_v1"}, {255'b0, dut_valid}, 256'd1);
        chk({nm, "_d1"}, dut_data, e1);
        idle(1);
        chk({nm, "_vend"}, {255'b0, dut_valid}, 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        chk("rst_valid", {255'b0, dut_valid}, 256'd0);
        chk("rst_data", dut_data, 256'd0);
        chk("rst_err", {255'b0, dut_err}, 256'd0);

        // basic write then read on bank 3 row 5
        step(1'b1, c_ACT, 5'd3, 12'd5, '0, 8'h00);
        idle(2);
        step(1'b1, c_WR, 5'd3, 12'd2, '0, 8'h00);
        beat(c_A, 8'h00);
        beat(c_B, 8'h00);
        idle(3);
        read_and_check("basic", 5'd3, 12'd2, c_A, c_B);
        chk("basic_err", {255'b0, dut_err}, 256'd0);

        // column wrap on bank 0 row 0
        step(1'b1, c_ACT, 5'd0, 12'd0, '0, 8'h00);
        step(1'b1, c_WR, 5'd0, 12'd1, '0, 8'h00);
        beat(c_E, 8'h00);
        beat(c_F, 8'h00);
        step(1'b1, c_WR, 5'd0, 12'd15, '0, 8'h00);
        beat(c_C, 8'h00);
        beat(c_D, 8'h00);
        idle(2);
        read_and_check("wrap15", 5'd0, 12'd15, c_C, c_D);
        idle(1);
        read_and_check("wrap0", 5'd0, 12'd0, c_D, c_E);

        // lane mask: only lane 1 keeps its preloaded ones
        step(1'b1, c_ACT, 5'd1, 12'd7, '0, 8'h00);
        step(1'b1, c_WR, 5'd1, 12'd4, '0, 8'h00);
        beat(c_ONES, 8'h00);
        beat(c_ONES, 8'h00);
        idle(1);
        step(1'b1, c_WR, 5'd1, 12'd4, '0, 8'h00);
        beat('0, 8'b0000_0010);
        beat('0, 8'b0000_0010);
        idle(2);
        read_and_check("mask", 5'd1, 12'd4, c_LANE1, c_LANE1);

        // closed-bank read, then back-to-back reads one cycle apart
        step(1'b1, c_RD, 5'd9, 12'd0, '0, 8'h00);
        step(1'b1, c_RD, 5'd3, 12'd2, '0, 8'h00);
        step(1'b1, c_RD, 5'd3, 12'd2, '0, 8'h00);
        idle(3);
        chk("b2b_d0", dut_data, c_A);
        idle(1);
        chk("b2b_d1", dut_data, c_B);
        idle(1);
        chk("b2b_vend", {255'b0, dut_valid}, 256'd0);
        chk("b2b_err", {255'b0, dut_err}, 256'd1);
        step(1'b1, c_ACT, 5'd3, 12'd5, '0, 8'h00);
        idle(3);

        // reset during the first read beat
        step(1'b1, c_RD, 5'd3, 12'd2, '0, 8'h00);
        idle(c_RD_LAT);
        chk("rmid_d0", dut_data, c_A);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        chk("rmid_valid", {255'b0, dut_valid}, 256'd0);
        chk("rmid_err", {255'b0, dut_err}, 256'd0);
        idle(1);
        chk("rmid_no2nd", {255'b0, dut_valid}, 256'd0);
        step(1'b1, c_RD, 5'd3, 12'd2, '0, 8'h00);
        idle(3);
        chk("rmid_closed_err", {255'b0, dut_err}, 256'd1);
        rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        step(1'b1, c_ACT, 5'd3, 12'd5, '0, 8'h00);
        idle(1);
        read_and_check("retain", 5'd3, 12'd2, c_A, c_B);

        // read beats coincide with write beats to the same address
        step(1'b1, c_ACT, 5'd2, 12'd1, '0, 8'h00);
        step(1'b1, c_WR, 5'd2, 12'd0, '0, 8'h00);
        beat(c_G, 8'h00);
        beat(c_H, 8'h00);
        idle(2);
        step(1'b1, c_RD, 5'd2, 12'd0, '0, 8'h00);
        idle(2);
        step(1'b1, c_WR, 5'd2, 12'd0, '0, 8'h00);
        beat(c_I, 8'h00);
        chk("same_d0", dut_data, c_G);
        beat(c_J, 8'h00);
        chk("same_d1", dut_data, c_H);
        idle(2);
        read_and_check("after", 5'd2, 12'd0, c_I, c_J);
        chk("final_err", {255'b0, dut_err}, 256'd0);

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
